// File: rtl/player_pkg.sv
// player_pkg: shared widths, direction/status enums and the lane lookup
// used by the player sprite controller.
package player_pkg;

    localparam int COORD_W   = 11;
    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE    = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    // True when pos lies in [base, base+size) for any lane slot. Unused slots
    // hold all-ones bases, whose range wraps to empty so they never match.
    function automatic logic in_lane(
        input logic [COORD_W-1:0]           pos,
        input logic [MAX_LANES*COORD_W-1:0] base_vec,
        input logic [COORD_W-1:0]           size
    );
        logic [COORD_W-1:0] base;
        logic [COORD_W-1:0] limit;
        logic               hit;
        hit = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            base  = base_vec[i*COORD_W +: COORD_W];
            limit = base + size;
            if ((pos >= base) && (pos < limit)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/player_sprite_rom.sv
// player_sprite_rom: synchronous-read sprite ROM, 3-bit rgb per pixel, with the
// read gated by an enable so it doubles as the final pixel pipeline register.
// The artwork is a fixed diagonal colour pattern derived from the pixel address.
module player_sprite_rom #(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int ADDR_W = $clog2(SPR_W) + $clog2(SPR_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        rgb
);

    localparam int XW = $clog2(SPR_W);

    logic [2:0] px;
    logic [2:0] py;
    logic [2:0] word;
    logic [2:0] rgb_d;
    logic [2:0] rgb_q;

    // Look up the sprite word for the addressed pixel; disabled reads give transparent.
    always_comb begin
        px    = 3'(addr[XW-1:0]);
        py    = 3'(addr[ADDR_W-1:XW]);
        word  = px * 3'd3 + py * 3'd5 + 3'd1;
        rgb_d = en ? word : 3'b000;
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 3'b000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/player_sprite_ctrl.sv
// player_sprite_ctrl: moves the player around the lane grid once per prescaled
// move tick and overlays its direction-mirrored ROM sprite on the pixel stream.
// Build option PLAYER_WRAP_EN: when defined, hp wraps between H_MIN and H_MAX;
// otherwise hp saturates at both bounds like vp.
module player_sprite_ctrl
    import player_pkg::*;
#(
    parameter int H_MIN     = 340,
    parameter int H_MAX     = 940,
    parameter int V_MIN     = 305,
    parameter int V_MAX     = 655,
    parameter int H_START   = 640,
    parameter int V_START   = 480,
    parameter int STEP      = 1,
    parameter int MOVE_DIV  = 416667,
    parameter int NUM_LANES = 3,
    parameter logic [NUM_LANES*COORD_W-1:0] HLANE_Y = {11'd645, 11'd475, 11'd300},
    parameter int HLANE_H   = 15,
    parameter logic [NUM_LANES*COORD_W-1:0] VLANE_X = {11'd875, 11'd625, 11'd375},
    parameter int VLANE_W   = 30,
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blank,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    output logic               r,
    output logic               g,
    output logic               b,
    output logic [COORD_W-1:0] location_left,
    output logic [COORD_W-1:0] location_right,
    output logic [1:0]         facing,
    output logic [1:0]         status
);

    localparam int PW = $clog2(MOVE_DIV);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);

    localparam logic [COORD_W-1:0] H_MIN_C  = COORD_W'(H_MIN);
    localparam logic [COORD_W-1:0] H_MAX_C  = COORD_W'(H_MAX);
    localparam logic [COORD_W-1:0] V_MIN_C  = COORD_W'(V_MIN);
    localparam logic [COORD_W-1:0] V_MAX_C  = COORD_W'(V_MAX);
    localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
    localparam logic [PW-1:0]      PRESC_LAST = PW'(MOVE_DIV - 1);

    logic [PW-1:0]                presc_q, presc_d;
    logic [COORD_W-1:0]           hp_q, hp_d;
    logic [COORD_W-1:0]           vp_q, vp_d;
    dir_t                         facing_q, facing_d;
    state_t                       status_q, status_d;
    logic                         tick;
    logic                         req;
    logic                         axis_ok;
    dir_t                         req_dir;
    logic                         h_ok;
    logic                         v_ok;
    logic [MAX_LANES*COORD_W-1:0] hlane_vec;
    logic [MAX_LANES*COORD_W-1:0] vlane_vec;

    logic [COORD_W-1:0]           x0, y0, dx, dy;
    logic [XW-1:0]                dx_m;
    logic                         in_box_q, in_box_d;
    logic                         blank_q, blank_d;
    logic [XW+YW-1:0]             addr_q, addr_d;
    logic [2:0]                   rgb;

    // Pad the lane tables to the lookup width and test which axes may move.
    always_comb begin
        hlane_vec = '1;
        vlane_vec = '1;
        hlane_vec[NUM_LANES*COORD_W-1:0] = HLANE_Y;
        vlane_vec[NUM_LANES*COORD_W-1:0] = VLANE_X;
        h_ok = in_lane(vp_q, hlane_vec, COORD_W'(HLANE_H));
        v_ok = in_lane(hp_q, vlane_vec, COORD_W'(VLANE_W));
    end

    // Prescaler, button priority and the IDLE/MOVE/BLOCKED decision on each tick.
    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        hp_d     = hp_q;
        vp_d     = vp_q;
        facing_d = facing_q;
        status_d = status_q;
        req      = 1'b1;
        req_dir  = RIGHT;
        axis_ok  = 1'b0;
        if (left) begin
            req_dir = LEFT;
            axis_ok = h_ok;
        end else if (right) begin
            req_dir = RIGHT;
            axis_ok = h_ok;
        end else if (up) begin
            req_dir = UP;
            axis_ok = v_ok;
        end else if (down) begin
            req_dir = DOWN;
            axis_ok = v_ok;
        end else begin
            req = 1'b0;
        end
        if (tick) begin
            if (!req) begin
                status_d = IDLE;
            end else if (!axis_ok) begin
                status_d = BLOCKED;
            end else begin
                status_d = MOVE;
                facing_d = req_dir;
                case (req_dir)
                    LEFT: begin
                        if (hp_q < H_MIN_C + STEP_C) begin
`ifdef PLAYER_WRAP_EN
                            hp_d = H_MAX_C;
`else
                            hp_d = H_MIN_C;
`endif
                        end else begin
                            hp_d = hp_q - STEP_C;
                        end
                    end
                    RIGHT: begin
                        if (hp_q > H_MAX_C - STEP_C) begin
`ifdef PLAYER_WRAP_EN
                            hp_d = H_MIN_C;
`else
                            hp_d = H_MAX_C;
`endif
                        end else begin
                            hp_d = hp_q + STEP_C;
                        end
                    end
                    UP: begin
                        if (vp_q < V_MIN_C + STEP_C) begin
                            vp_d = V_MIN_C;
                        end else begin
                            vp_d = vp_q - STEP_C;
                        end
                    end
                    DOWN: begin
                        if (vp_q > V_MAX_C - STEP_C) begin
                            vp_d = V_MAX_C;
                        end else begin
                            vp_d = vp_q + STEP_C;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Sprite box test and ROM address (mirrored when facing left) for stage 1.
    always_comb begin
        x0       = hp_q - COORD_W'(SPR_W / 2);
        y0       = vp_q - COORD_W'(SPR_H / 2);
        dx       = hcount - x0;
        dy       = vcount - y0;
        in_box_d = (dx < COORD_W'(SPR_W)) && (dy < COORD_W'(SPR_H));
        dx_m     = (facing_q == LEFT) ? ~dx[XW-1:0] : dx[XW-1:0];
        addr_d   = {dy[YW-1:0], dx_m};
        blank_d  = blank;
    end

    // Movement state and pixel stage-1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            hp_q     <= COORD_W'(H_START);
            vp_q     <= COORD_W'(V_START);
            facing_q <= RIGHT;
            status_q <= IDLE;
            in_box_q <= 1'b0;
            blank_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            hp_q     <= hp_d;
            vp_q     <= vp_d;
            facing_q <= facing_d;
            status_q <= status_d;
            in_box_q <= in_box_d;
            blank_q  <= blank_d;
            addr_q   <= addr_d;
        end
    end

    player_sprite_rom #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (XW + YW)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_box_q & ~blank_q),
        .addr  (addr_q),
        .rgb   (rgb)
    );

    assign {r, g, b}      = rgb;
    assign location_left  = x0;
    assign location_right = x0 + COORD_W'(SPR_W - 1);
    assign facing         = facing_q;
    assign status         = status_q;

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// tb_player_sprite_ctrl: directed and randomized checks of the player controller
// against a behavioural position/pixel model (MOVE_DIV = 4, default lanes).
`timescale 1ns/1ps
module tb_player_sprite_ctrl;

    localparam int MOVE_DIV = 4;
`ifdef PLAYER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank = 1'b1;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic        r, g, b;
    logic [10:0] location_left, location_right;
    logic [1:0]  facing, status;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_hp, m_vp, m_facing, m_status, m_cnt, m_s1, m_rgb;
    bit m_ticked;
    int hl[3] = '{300, 475, 645};
    int vl[3] = '{375, 625, 875};

    player_sprite_ctrl #(.MOVE_DIV(MOVE_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .blank          (blank),
        .hcount         (hcount),
        .vcount         (vcount),
        .left           (left),
        .right          (right),
        .up             (up),
        .down           (down),
        .r              (r),
        .g              (g),
        .b              (b),
        .location_left  (location_left),
        .location_right (location_right),
        .facing         (facing),
        .status         (status)
    );

    always #5 clk = ~clk;

    function automatic int rom_model(int x, int y);
        return (x * 3 + y * 5 + 1) % 8;
    endfunction

    function automatic int pix_model(int hc, int vc, logic bl);
        int dx, dy;
        if (bl) return 0;
        dx = hc - (m_hp - 8);
        dy = vc - (m_vp - 8);
        if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return 0;
        if (m_facing == 0) dx = 15 - dx;
        return rom_model(dx, dy);
    endfunction

    function automatic bit lane_hit(int pos, bit horiz);
        bit hit = 0;
        for (int i = 0; i < 3; i++) begin
            if (horiz && pos >= hl[i] && pos < hl[i] + 15) hit = 1;
            if (!horiz && pos >= vl[i] && pos < vl[i] + 30) hit = 1;
        end
        return hit;
    endfunction

    task automatic model_reset();
        m_hp = 640; m_vp = 480; m_facing = 1; m_status = 0;
        m_cnt = 0; m_s1 = 0; m_rgb = 0; m_ticked = 0;
    endtask

    task automatic apply_tick();
        int dir, n;
        dir = left ? 0 : right ? 1 : up ? 2 : down ? 3 : -1;
        if (dir < 0) begin
            m_status = 0;
        end else if (!lane_hit(dir < 2 ? m_vp : m_hp, dir < 2)) begin
            m_status = 2;
        end else begin
            m_status = 1;
            m_facing = dir;
            case (dir)
                0: begin n = m_hp - 1; if (n < 340) n = WRAP ? 940 : 340; m_hp = n; end
                1: begin n = m_hp + 1; if (n > 940) n = WRAP ? 340 : 940; m_hp = n; end
                2: begin n = m_vp - 1; if (n < 305) n = 305; m_vp = n; end
                default: begin n = m_vp + 1; if (n > 655) n = 655; m_vp = n; end
            endcase
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        if (rst_n) begin
            m_rgb = m_s1;
            m_s1  = pix_model(int'(hcount), int'(vcount), blank);
            if (m_cnt == MOVE_DIV - 1) begin
                apply_tick();
                m_ticked = 1;
            end
            m_cnt = (m_cnt + 1) % MOVE_DIV;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic l, input logic rr, input logic u, input logic d);
        left = l; right = rr; up = u; down = d;
        m_ticked = 0;
        for (int i = 0; i < MOVE_DIV && !m_ticked; i++) clk_cycle();
        left = 0; right = 0; up = 0; down = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        left = 0; right = 0; up = 0; down = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (location_left !== 11'd632) begin failures++; $display("[TB] FAIL reset_loc_left got %0d want 632", location_left); end
        checks++; if (location_right !== 11'd647) begin failures++; $display("[TB] FAIL reset_loc_right got %0d want 647", location_right); end
        checks++; if (status !== 2'd0) begin failures++; $display("[TB] FAIL reset_status got %0d want 0", status); end
        checks++; if (facing !== 2'd1) begin failures++; $display("[TB] FAIL reset_facing got %0d want 1", facing); end
        checks++; if ({r, g, b} !== 3'b000) begin failures++; $display("[TB] FAIL reset_rgb got %b want 000", {r, g, b}); end
        rst_n = 1'b1;
    endtask

    task automatic test_right_held();
        do_reset();
        right = 1;
        for (int i = 0; i < 3 * MOVE_DIV; i++) begin
            clk_cycle();
            checks++;
            if (location_left !== 11'(m_hp - 8)) begin
                failures++;
                $display("[TB] FAIL right_step cyc%0d got %0d want %0d", i, location_left, m_hp - 8);
            end
        end
        right = 0;
        checks++; if (location_left !== 11'd635) begin failures++; $display("[TB] FAIL right_final got %0d want 635", location_left); end
        checks++; if (status !== 2'd1) begin failures++; $display("[TB] FAIL right_status got %0d want 1", status); end
        checks++; if (facing !== 2'd1) begin failures++; $display("[TB] FAIL right_facing got %0d want 1", facing); end
    endtask

    task automatic test_between_ticks();
        do_reset();
        for (int i = 0; i < 3 * MOVE_DIV; i++) begin
            right = (m_cnt != MOVE_DIV - 1);
            clk_cycle();
        end
        right = 0;
        checks++; if (location_left !== 11'd632) begin failures++; $display("[TB] FAIL between_ticks got %0d want 632", location_left); end
        checks++; if (status !== 2'd0) begin failures++; $display("[TB] FAIL between_status got %0d want 0", status); end
    endtask

    task automatic test_left_up();
        do_reset();
        applyStimulus(1, 0, 1, 0);
        checks++; if (location_left !== 11'd631) begin failures++; $display("[TB] FAIL left_up_loc got %0d want 631", location_left); end
        checks++; if (facing !== 2'd0) begin failures++; $display("[TB] FAIL left_up_facing got %0d want 0", facing); end
    endtask

    task automatic test_left_edge();
        int want;
        do_reset();
        for (int i = 0; i < 400 && m_hp != 340; i++) applyStimulus(1, 0, 0, 0);
        checks++; if (location_left !== 11'd332) begin failures++; $display("[TB] FAIL edge_reach got %0d want 332", location_left); end
        applyStimulus(1, 0, 0, 0);
        want = WRAP ? 932 : 332;
        checks++; if (location_left !== 11'(want)) begin failures++; $display("[TB] FAIL edge_left got %0d want %0d", location_left, want); end
        checks++; if (status !== 2'd1) begin failures++; $display("[TB] FAIL edge_status got %0d want 1", status); end
    endtask

    task automatic test_blocked();
        do_reset();
        for (int i = 0; i < 200 && m_hp != 500; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checks++; if (location_left !== 11'd492) begin failures++; $display("[TB] FAIL blocked_loc got %0d want 492", location_left); end
        checks++; if (status !== 2'd2) begin failures++; $display("[TB] FAIL blocked_status got %0d want 2", status); end
        checks++; if (facing !== 2'd0) begin failures++; $display("[TB] FAIL blocked_facing got %0d want 0", facing); end
        hcount = 11'd492; vcount = 11'd472; blank = 0;
        clk_cycle(); clk_cycle();
        checks++; if ({r, g, b} !== 3'd6) begin failures++; $display("[TB] FAIL blocked_vp_pixel got %0d want 6", {r, g, b}); end
        blank = 1;
    endtask

    task automatic test_pixel();
        do_reset();
        hcount = 11'd632; vcount = 11'd472; blank = 0;
        clk_cycle();
        checks++; if ({r, g, b} !== 3'd0) begin failures++; $display("[TB] FAIL pix_latency1 got %0d want 0", {r, g, b}); end
        clk_cycle();
        checks++; if ({r, g, b} !== 3'd1) begin failures++; $display("[TB] FAIL pix_rom00 got %0d want 1", {r, g, b}); end
        applyStimulus(1, 0, 0, 0);
        hcount = 11'd631;
        clk_cycle(); clk_cycle();
        checks++; if ({r, g, b} !== 3'd6) begin failures++; $display("[TB] FAIL pix_mirror got %0d want 6", {r, g, b}); end
        blank = 1;
        clk_cycle(); clk_cycle();
        checks++; if ({r, g, b} !== 3'd0) begin failures++; $display("[TB] FAIL pix_blank got %0d want 0", {r, g, b}); end
        blank = 0; hcount = 11'd647;
        clk_cycle(); clk_cycle();
        checks++; if ({r, g, b} !== 3'd0) begin failures++; $display("[TB] FAIL pix_outside got %0d want 0", {r, g, b}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            left   = ($urandom_range(0, 3) == 0);
            right  = ($urandom_range(0, 3) == 0);
            up     = ($urandom_range(0, 3) == 0);
            down   = ($urandom_range(0, 3) == 0);
            blank  = ($urandom_range(0, 7) == 0);
            hcount = 11'(m_hp - 12 + int'($urandom_range(0, 24)));
            vcount = 11'(m_vp - 12 + int'($urandom_range(0, 24)));
            clk_cycle();
            checks++;
            if (location_left !== 11'(m_hp - 8) || location_right !== 11'(m_hp + 7)) begin
                failures++;
                $display("[TB] FAIL rand_loc cyc%0d got %0d/%0d want %0d/%0d", i, location_left, location_right, m_hp - 8, m_hp + 7);
            end
            checks++;
            if (facing !== 2'(m_facing) || status !== 2'(m_status)) begin
                failures++;
                $display("[TB] FAIL rand_state cyc%0d got f%0d s%0d want f%0d s%0d", i, facing, status, m_facing, m_status);
            end
            checks++;
            if ({r, g, b} !== 3'(m_rgb)) begin
                failures++;
                $display("[TB] FAIL rand_rgb cyc%0d got %0d want %0d", i, {r, g, b}, m_rgb);
            end
        end
        left = 0; right = 0; up = 0; down = 0; blank = 1;
    endtask

    task automatic test_reset_mid();
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (location_left !== 11'd632) begin failures++; $display("[TB] FAIL mid_reset_loc got %0d want 632", location_left); end
        checks++; if (status !== 2'd0 || facing !== 2'd1) begin failures++; $display("[TB] FAIL mid_reset_state got s%0d f%0d want s0 f1", status, facing); end
        checks++; if ({r, g, b} !== 3'd0) begin failures++; $display("[TB] FAIL mid_reset_rgb got %0d want 0", {r, g, b}); end
        do_reset();
        right = 1;
        for (int i = 0; i < MOVE_DIV - 1; i++) clk_cycle();
        checks++; if (location_left !== 11'd632) begin failures++; $display("[TB] FAIL post_reset_early got %0d want 632", location_left); end
        clk_cycle();
        checks++; if (location_left !== 11'd633) begin failures++; $display("[TB] FAIL post_reset_first got %0d want 633", location_left); end
        right = 0;
    endtask

    initial begin
        $display("[TB] player_sprite_ctrl bench, wrap=%0d", WRAP);
        test_reset();
        test_right_held();
        test_between_ticks();
        test_left_up();
        test_left_edge();
        test_blocked();
        test_pixel();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
